rv32_id_ex_stage: RTL and testbench

ID/EX pipeline register plus EX-stage operand selection for the 5-stage RV32I core. Captures decoded fields from ID and resolves register forwarding from EX/MEM and MEM/WB. Drives opA, opB and alu_opsel into the ALU submodules (logical, arithmetic, shift). Detects load-use hazards and inserts bubbles.

---
 rtl/rv32_id_ex_stage.sv | 133 +++++++++++++
 tb/tb_rv32_id_ex_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Forwarding and hazard logic are combinational off the registered EX contents.
module rv32_id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 id_valid,
  input  logic [REGADDR_W-1:0] id_rs1_addr,
  input  logic [REGADDR_W-1:0] id_rs2_addr,
  input  logic [REGADDR_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [4:0]           id_alu_opsel,
  input  logic                 id_use_imm,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic [REGADDR_W-1:0] exmem_rd,
  input  logic                 exmem_reg_write,
  input  logic [XLEN-1:0]      exmem_result,
  input  logic [REGADDR_W-1:0] memwb_rd,
  input  logic                 memwb_reg_write,
  input  logic [XLEN-1:0]      memwb_result,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_opA,
  output logic [XLEN-1:0]      ex_opB,
  output logic [XLEN-1:0]      ex_store_data,
  output logic [4:0]           ex_alu_opsel,
  output logic [REGADDR_W-1:0] ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 hazard_stall
);

  typedef struct packed {
    logic                 valid;
    logic [REGADDR_W-1:0] rs1_addr;
    logic [REGADDR_W-1:0] rs2_addr;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic [4:0]           alu_opsel;
    logic                 use_imm;
    logic                 reg_write;
    logic                 mem_read;
  } idex_t;

  idex_t idex_q, idex_d;
  logic  rs1_hit, rs2_hit;
  logic  [XLEN-1:0] rs1_fwd, rs2_fwd;

  // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGADDR_W-1:0] rs,
    input logic [XLEN-1:0]      reg_val,
    input logic                 em_we,
    input logic [REGADDR_W-1:0] em_rd,
    input logic [XLEN-1:0]      em_val,
    input logic                 mw_we,
    input logic [REGADDR_W-1:0] mw_rd,
    input logic [XLEN-1:0]      mw_val
  );
    if (em_we && (em_rd != '0) && (em_rd == rs)) begin
      return em_val;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == rs)) begin
      return mw_val;
    end
    return reg_val;
  endfunction

  assign rs1_hit = id_uses_rs1 && (id_rs1_addr == idex_q.rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2_addr == idex_q.rd);

  assign hazard_stall = !flush_i && idex_q.valid && idex_q.mem_read &&
                        (idex_q.rd != '0) && (rs1_hit || rs2_hit);

  // Update priority: flush, then external stall, then load-use bubble, then load.
  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (!stall_i) begin
      if (hazard_stall || !id_valid) begin
        idex_d = '0;
      end else begin
        idex_d.valid     = 1'b1;
        idex_d.rs1_addr  = id_rs1_addr;
        idex_d.rs2_addr  = id_rs2_addr;
        idex_d.rd        = id_rd_addr;
        idex_d.rs1_data  = id_rs1_data;
        idex_d.rs2_data  = id_rs2_data;
        idex_d.imm       = id_imm;
        idex_d.alu_opsel = id_alu_opsel;
        idex_d.use_imm   = id_use_imm;
        idex_d.reg_write = id_reg_write;
        idex_d.mem_read  = id_mem_read;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // EX stage: operand selection off the registered ID/EX contents
  assign rs1_fwd = fwd_sel(idex_q.rs1_addr, idex_q.rs1_data,
                           exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);
  assign rs2_fwd = fwd_sel(idex_q.rs2_addr, idex_q.rs2_data,
                           exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);

  assign ex_valid      = idex_q.valid;
  assign ex_opA        = rs1_fwd;
  assign ex_opB        = idex_q.use_imm ? idex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_alu_opsel  = idex_q.alu_opsel;
  assign ex_rd         = idex_q.rd;
  assign ex_reg_write  = idex_q.reg_write;
  assign ex_mem_read   = idex_q.mem_read;

endmodule

// File: tb/tb_rv32_id_ex_stage.sv
// Bench for rv32_id_ex_stage: directed scenarios plus randomized traffic against a rule-level model.
module tb_rv32_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_opsel;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, hazard_stall;
  logic [31:0] ex_opA, ex_opB, ex_store_data;
  logic [4:0]  ex_alu_opsel, ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the instruction currently sitting in EX.
  logic        m_valid, m_useimm, m_rw, m_mr;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_op;
  logic [31:0] m_d1, m_d2, m_imm;

  always #5 clk = ~clk;

  rv32_id_ex_stage #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alu_opsel(id_alu_opsel), .id_use_imm(id_use_imm),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_store_data(ex_store_data),
    .ex_alu_opsel(ex_alu_opsel), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall)
  );

  function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] regval);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == a) return memwb_result;
    return regval;
  endfunction

  function automatic logic model_hazard();
    if (flush_i || !m_valid || !m_mr || m_rd == 0) return 1'b0;
    return (id_uses_rs1 && id_rs1_addr == m_rd) || (id_uses_rs2 && id_rs2_addr == m_rd);
  endfunction

  task automatic model_clear();
    {m_valid, m_useimm, m_rw, m_mr} = '0;
    {m_rs1, m_rs2, m_rd, m_op} = '0;
    {m_d1, m_d2, m_imm} = '0;
  endtask

  // Apply the edge rules to the model using the inputs present just before the edge.
  task automatic model_clock();
    if (rst || flush_i) begin
      model_clear();
    end else if (!stall_i) begin
      if (model_hazard() || !id_valid) begin
        model_clear();
      end else begin
        m_valid = 1'b1; m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr; m_rd = id_rd_addr;
        m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_op = id_alu_opsel;
        m_useimm = id_use_imm; m_rw = id_reg_write; m_mr = id_mem_read;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [4:0] op, input logic ui,
                        input logic u1, input logic u2, input logic rw, input logic mr);
    id_valid = v; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
    id_rd_addr = rd; id_imm = imm; id_alu_opsel = op; id_use_imm = ui;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic no_forward();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    rst = 1; stall_i = 0; flush_i = 0;
    no_forward();
    set_id(1, 1, 32'h1234, 2, 32'h5678, 3, 32'h9, 2, 0, 1, 1, 1, 0);
    tick();
    tick();
    rst = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
    n_checks++; if (ex_alu_opsel !== 5'd0) begin n_fail++; $display("FAIL reset_opsel: got %0d expected 0", ex_alu_opsel); end
    n_checks++; if ({ex_reg_write, ex_mem_read, ex_rd} !== 7'd0) begin n_fail++; $display("FAIL reset_ctrl: got rw=%b mr=%b rd=%0d expected all 0", ex_reg_write, ex_mem_read, ex_rd); end
    n_checks++; if ({ex_opA, ex_opB, ex_store_data} !== 96'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h expected 0", ex_opA, ex_opB, ex_store_data); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall); end
  endtask

  task automatic test_and();
    no_forward();
    set_id(1, 1, 32'hF0F0_F0F0, 2, 32'h0FF0_0FF0, 3, 32'h0, 2, 0, 1, 1, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (ex_opA !== 32'hF0F0F0F0) begin n_fail++; $display("FAIL and_opA: got %h expected f0f0f0f0", ex_opA); end
    n_checks++; if (ex_opB !== 32'h0FF00FF0) begin n_fail++; $display("FAIL and_opB: got %h expected 0ff00ff0", ex_opB); end
    n_checks++; if (ex_alu_opsel !== 5'd2 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL and_ctrl: got op=%0d valid=%b expected op=2 valid=1", ex_alu_opsel, ex_valid); end
  endtask

  task automatic test_ori();
    no_forward();
    set_id(1, 4, 32'hAAAA_5555, 6, 32'h1234_5678, 8, 32'h0000_00FF, 10, 1, 1, 0, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (ex_opB !== 32'h000000FF) begin n_fail++; $display("FAIL ori_opB: got %h expected 000000ff", ex_opB); end
    n_checks++; if (ex_store_data !== 32'h12345678) begin n_fail++; $display("FAIL ori_store: got %h expected 12345678", ex_store_data); end
    n_checks++; if (ex_alu_opsel !== 5'd10 || ex_rd !== 5'd8) begin n_fail++; $display("FAIL ori_ctrl: got op=%0d rd=%0d expected op=10 rd=8", ex_alu_opsel, ex_rd); end
  endtask

  task automatic test_forward();
    no_forward();
    set_id(1, 5, 32'h0000_DEAD, 6, 32'h0000_0033, 9, 0, 3, 0, 1, 1, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h1111_1111;
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h2222_2222;
    #1;
    n_checks++; if (ex_opA !== 32'h11111111) begin n_fail++; $display("FAIL fwd_exmem_wins: got %h expected 11111111", ex_opA); end
    n_checks++; if (ex_opB !== 32'h00000033) begin n_fail++; $display("FAIL fwd_rs2_untouched: got %h expected 00000033", ex_opB); end
    exmem_reg_write = 0;
    #1;
    n_checks++; if (ex_opA !== 32'h22222222) begin n_fail++; $display("FAIL fwd_memwb: got %h expected 22222222", ex_opA); end
    no_forward();
    set_id(1, 0, 32'h5A5A_5A5A, 0, 32'h6B6B_6B6B, 9, 0, 3, 0, 1, 1, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'h1111_1111;
    memwb_rd = 0; memwb_reg_write = 1; memwb_result = 32'h2222_2222;
    #1;
    n_checks++; if (ex_opA !== 32'h5A5A5A5A || ex_store_data !== 32'h6B6B6B6B) begin n_fail++; $display("FAIL fwd_x0: got %h %h expected 5a5a5a5a 6b6b6b6b", ex_opA, ex_store_data); end
    no_forward();
  endtask

  task automatic test_load_use();
    no_forward();
    set_id(1, 2, 32'h100, 0, 0, 7, 32'h4, 0, 1, 1, 0, 1, 1);
    tick();
    set_id(1, 3, 32'h33, 7, 32'h77, 10, 0, 4, 0, 1, 1, 1, 0);
    #1;
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_detect: got %b expected 1", hazard_stall); end
    tick();
    n_checks++; if ({ex_valid, ex_alu_opsel, ex_reg_write} !== 7'd0) begin n_fail++; $display("FAIL loaduse_bubble: got valid=%b op=%0d rw=%b expected 0", ex_valid, ex_alu_opsel, ex_reg_write); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release: got %b expected 0", hazard_stall); end
    tick();
    n_checks++; if (ex_alu_opsel !== 5'd4 || ex_opB !== 32'h77) begin n_fail++; $display("FAIL loaduse_reissue: got op=%0d opB=%h expected 4 00000077", ex_alu_opsel, ex_opB); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall_flush();
    no_forward();
    set_id(1, 1, 32'hAAAA_0000, 2, 32'h0000_BBBB, 3, 0, 2, 0, 1, 1, 1, 0);
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 4, $urandom, 5, $urandom, 6, $urandom, 11, 1, 1, 1, 1, 1);
      tick();
      n_checks++; if (ex_opA !== 32'hAAAA0000 || ex_opB !== 32'h0000BBBB || ex_alu_opsel !== 5'd2 || ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
        n_fail++; $display("FAIL stall_hold: got opA=%h opB=%h op=%0d valid=%b rd=%0d expected aaaa0000 0000bbbb 2 1 3", ex_opA, ex_opB, ex_alu_opsel, ex_valid, ex_rd);
      end
    end
    flush_i = 1;
    tick();
    n_checks++; if ({ex_valid, ex_alu_opsel, ex_reg_write, ex_mem_read} !== 8'd0) begin n_fail++; $display("FAIL stall_flush_bubble: got valid=%b op=%0d rw=%b mr=%b expected 0", ex_valid, ex_alu_opsel, ex_reg_write, ex_mem_read); end
    stall_i = 0; flush_i = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_hazard();
    no_forward();
    set_id(1, 1, 32'h10, 0, 0, 12, 0, 0, 1, 1, 0, 1, 1);
    tick();
    set_id(1, 12, 32'h20, 1, 32'h30, 13, 0, 3, 0, 1, 1, 1, 0);
    #1;
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL rsthaz_detect: got %b expected 1", hazard_stall); end
    flush_i = 1;
    #1;
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL flush_masks_hazard: got %b expected 0", hazard_stall); end
    flush_i = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_checks++; if ({ex_valid, ex_alu_opsel, ex_reg_write, ex_mem_read, ex_rd} !== 13'd0) begin n_fail++; $display("FAIL rsthaz_ctrl: got valid=%b op=%0d rw=%b mr=%b rd=%0d expected 0", ex_valid, ex_alu_opsel, ex_reg_write, ex_mem_read, ex_rd); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rsthaz_hazard: got %b expected 0", hazard_stall); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] e_a, e_b, e_s;
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      stall_i = ($urandom_range(0, 5) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 11)), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 2) == 0));
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      #1;
      e_a = model_fwd(m_rs1, m_d1);
      e_s = model_fwd(m_rs2, m_d2);
      e_b = m_useimm ? m_imm : e_s;
      n_checks++; if (hazard_stall !== model_hazard()) begin n_fail++; $display("FAIL rnd_hazard[%0d]: got %b expected %b", i, hazard_stall, model_hazard()); end
      n_checks++; if (ex_opA !== e_a || ex_opB !== e_b || ex_store_data !== e_s) begin
        n_fail++; $display("FAIL rnd_operands[%0d]: got %h %h %h expected %h %h %h", i, ex_opA, ex_opB, ex_store_data, e_a, e_b, e_s);
      end
      n_checks++; if ({ex_valid, ex_alu_opsel, ex_rd, ex_reg_write, ex_mem_read} !== {m_valid, m_op, m_rd, m_rw, m_mr}) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: got v=%b op=%0d rd=%0d rw=%b mr=%b expected v=%b op=%0d rd=%0d rw=%b mr=%b", i,
                           ex_valid, ex_alu_opsel, ex_rd, ex_reg_write, ex_mem_read, m_valid, m_op, m_rd, m_rw, m_mr);
      end
      tick();
    end
    rst = 0; stall_i = 0; flush_i = 0;
  endtask

  initial begin
    rst = 1; stall_i = 0; flush_i = 0;
    no_forward();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    test_reset();
    test_and();
    test_ori();
    test_forward();
    test_load_use();
    test_stall_flush();
    test_rst_hazard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
